// File: rtl/sdp_ram_hs.sv
// sdp_ram_hs: dual-port RAM, byte-masked write, valid/ready read with RDELAY latency; define SDP_RAM_HS_BYPASS_EN for write-to-read collision bypass
module sdp_ram_hs #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RDELAY     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wvalid,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    arvalid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rready
);
    localparam int NB = DATA_WIDTH / 8;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word;
    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (wvalid && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef SDP_RAM_HS_BYPASS_EN
    always_comb begin
        rd_word = mem[araddr];
        for (int i = 0; i < NB; i++)
            if (wvalid && wstrb[i] && waddr == araddr) rd_word[8*i +: 8] = wdata[8*i +: 8];
    end
`else
    assign rd_word = mem[araddr];
`endif
    if (RDELAY == 0) begin : g_comb
        assign arready = rready;
        assign rvalid  = arvalid;
        assign rdata   = rd_word;
    end else begin : g_pipe
        localparam int D  = RDELAY + 1;
        localparam int CW = $clog2(RDELAY + 2);
        localparam int PW = $clog2(D);
        logic                  acc, pop, push_v;
        logic [DATA_WIDTH-1:0] push_d;
        logic [CW-1:0]         outstanding, fc;
        logic [PW-1:0]         wp, rp;
        logic [DATA_WIDTH-1:0] fm [D];
        assign arready = outstanding < CW'(D);
        assign acc     = arvalid && arready;
        assign rvalid  = fc != '0;
        assign pop     = rvalid && rready;
        assign rdata   = rvalid ? fm[rp] : '0;
        if (RDELAY == 1) begin : g_direct
            assign push_v = acc;
            assign push_d = rd_word;
        end else begin : g_stages
            logic                  pv [RDELAY-1];
            logic [DATA_WIDTH-1:0] pd [RDELAY-1];
            always_ff @(posedge clk) begin
                pv[0] <= rst ? 1'b0 : acc;
                pd[0] <= rd_word;
                for (int k = 1; k < RDELAY - 1; k++) begin
                    pv[k] <= rst ? 1'b0 : pv[k-1];
                    pd[k] <= pd[k-1];
                end
            end
            assign push_v = pv[RDELAY-2];
            assign push_d = pd[RDELAY-2];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                outstanding <= '0;
                fc          <= '0;
                wp          <= '0;
                rp          <= '0;
            end else begin
                outstanding <= outstanding + CW'(acc) - CW'(pop);
                fc          <= fc + CW'(push_v) - CW'(pop);
                if (push_v) wp <= (wp == PW'(D - 1)) ? '0 : wp + PW'(1);
                if (pop) rp <= (rp == PW'(D - 1)) ? '0 : rp + PW'(1);
            end
            if (push_v) fm[wp] <= push_d;
        end
    end
endmodule

// File: tb/tb_sdp_ram_hs.sv
// tb_sdp_ram_hs: directed checks of sdp_ram_hs at RDELAY 0..4 sharing one write bus
module tb_sdp_ram_hs;
    logic        clk, rst, wvalid;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        arv [5];
    logic [9:0]  ara [5];
    logic        rr  [5];
    logic        ar  [5];
    logic        rv  [5];
    logic [31:0] rd  [5];
    int          n_chk = 0, n_pass = 0;
    int          idx, nb, first, last, lacc;
    logic        acc;
    logic [31:0] col_exp;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sdp_ram_hs #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RDELAY(g)) u_dut (
            .clk(clk), .rst(rst),
            .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
            .arvalid(arv[g]), .araddr(ara[g]), .arready(ar[g]),
            .rvalid(rv[g]), .rdata(rd[g]), .rready(rr[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        wvalid = 1; waddr = a; wdata = d; wstrb = s;
        step;
        wvalid = 0; wstrb = 0;
    endtask

    task automatic rd_chk(input int g, input logic [9:0] a, input logic [31:0] e, input string tag, input bit col);
        if (col) begin
            wvalid = 1; waddr = a; wdata = 32'h1234_5678; wstrb = 4'hF;
        end
        arv[g] = 1; ara[g] = a; rr[g] = 1;
        #1;
        if (g == 0) begin
            check($sformatf("%s_d%0d_rv", tag, g), rv[g], 1);
            check($sformatf("%s_d%0d_rd", tag, g), rd[g], e);
            step;
            arv[g] = 0; wvalid = 0; wstrb = 0;
        end else begin
            check($sformatf("%s_d%0d_ar", tag, g), ar[g], 1);
            step;
            arv[g] = 0; wvalid = 0; wstrb = 0;
            for (int i = 1; i < g; i++) begin
                check($sformatf("%s_d%0d_early", tag, g), rv[g], 0);
                step;
            end
            check($sformatf("%s_d%0d_rv", tag, g), rv[g], 1);
            check($sformatf("%s_d%0d_rd", tag, g), rd[g], e);
            step;
            check($sformatf("%s_d%0d_pop", tag, g), rv[g], 0);
        end
        rr[g] = 0;
    endtask

    initial begin
`ifdef SDP_RAM_HS_BYPASS_EN
        col_exp = 32'h1234_5678;
`else
        col_exp = 32'h0;
`endif
        clk = 0; rst = 1; wvalid = 0; waddr = 0; wdata = 0; wstrb = 0;
        for (int g = 0; g < 5; g++) begin
            arv[g] = 0; ara[g] = 0; rr[g] = 0;
        end
        step;
        step;
        rst = 0;
        check("rst_d0_rv", rv[0], 0);
        for (int g = 1; g < 5; g++) begin
            check($sformatf("rst_d%0d_rv", g), rv[g], 0);
            check($sformatf("rst_d%0d_ar", g), ar[g], 1);
            check($sformatf("rst_d%0d_rd", g), rd[g], 0);
        end

        wr(5, 32'hDEAD_BEEF, 4'hF);
        for (int g = 0; g < 5; g++) rd_chk(g, 5, 32'hDEAD_BEEF, "basic", 0);

        wr(3, 32'h1122_3344, 4'hF);
        wr(3, 32'hAABB_CCDD, 4'b0101);
        for (int g = 0; g < 5; g++) rd_chk(g, 3, 32'h11BB_33DD, "mask", 0);
        wr(3, 32'hFFFF_FFFF, 4'h0);
        rd_chk(1, 3, 32'h11BB_33DD, "nostrb", 0);

        for (int g = 0; g < 5; g++) begin
            wr(7, 32'h0, 4'hF);
            rd_chk(g, 7, col_exp, "col", 1);
            rd_chk(g, 7, 32'h1234_5678, "colpost", 0);
        end

        for (int i = 0; i < 6; i++) wr(10'(i), 32'h100 + i, 4'hF);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            arv[2] = idx < 6; ara[2] = 10'(idx);
            #1;
            acc = arv[2] && ar[2];
            step;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 3);
        check("bp_ar_low", ar[2], 0);
        check("bp_rv_hold", rv[2], 1);
        check("bp_rd_hold", rd[2], 32'h100);
        rr[2] = 1; nb = 0;
        for (int c = 0; c < 30 && nb < 6; c++) begin
            arv[2] = idx < 6; ara[2] = 10'(idx);
            #1;
            acc = arv[2] && ar[2];
            if (rv[2]) begin
                check($sformatf("bp_beat%0d", nb), rd[2], 32'h100 + nb);
                nb++;
            end
            step;
            if (acc) idx++;
        end
        arv[2] = 0;
        check("bp_beats", nb, 6);
        check("bp_all_acc", idx, 6);
        step;
        step;
        check("bp_no_dup", rv[2], 0);
        rr[2] = 0;

        wr(9, 32'hCAFE_F00D, 4'hF);
        arv[3] = 1; ara[3] = 9; rr[3] = 1;
        step;
        step;
        arv[3] = 0;
        check("mid_rv_pre", rv[3], 0);
        rst = 1;
        step;
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("mid_rv%0d", c), rv[3], 0);
            check($sformatf("mid_ar%0d", c), ar[3], 1);
            step;
        end
        rr[3] = 0;
        rd_chk(3, 9, 32'hCAFE_F00D, "mid_mem", 0);
        rd_chk(1, 3, 32'h0000_0103, "mid_mem", 0);

        for (int i = 0; i < 64; i++) wr(10'(i), 32'hA000_0000 + i, 4'hF);
        idx = 0; nb = 0; first = -1; last = -1; lacc = -1;
        rr[4] = 1;
        for (int c = 0; c < 100 && nb < 64; c++) begin
            arv[4] = idx < 64; ara[4] = 10'(idx);
            #1;
            acc = arv[4] && ar[4];
            if (rv[4]) begin
                check($sformatf("st_beat%0d", nb), rd[4], 32'hA000_0000 + nb);
                if (first < 0) first = c;
                last = c;
                nb++;
            end
            if (acc) lacc = c;
            step;
            if (acc) idx++;
        end
        arv[4] = 0; rr[4] = 0;
        check("st_beats", nb, 64);
        check("st_first", first, 4);
        check("st_last", last, 67);
        check("st_last_acc", lacc, 63);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
